// File: rtl/tl_tracker_pkg.sv
// Shared types and sizing for the TL response state tracker.
// Contents: slot_t (stored request state), out_hdr_t (response header),
// beats_of() (beats per transfer for a given log2 size), counter width.
package tl_tracker_pkg;

  localparam int unsigned NUM_IDS         = 4;
  localparam int unsigned ID_W            = $clog2(NUM_IDS);
  localparam int unsigned SIZE_W          = 4;
  localparam int unsigned SOURCE_W        = 5;
  localparam int unsigned BEAT_BYTES_LOG2 = 3;

  // Counter must reach beats-1 for the largest encodable size.
  localparam int unsigned MAX_SIZE = (1 << SIZE_W) - 1;
  localparam int unsigned CNT_W    = (MAX_SIZE > BEAT_BYTES_LOG2) ? (MAX_SIZE - BEAT_BYTES_LOG2) : 1;
  localparam int unsigned BEATS_W  = CNT_W + 1;

  typedef struct packed {
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic                extra_id;
  } slot_t;

  typedef struct packed {
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic                extra_id;
    logic                first;
    logic                last;
    logic                denied;
  } out_hdr_t;

  // Number of response beats for a transfer of 2**size bytes.
  function automatic logic [BEATS_W-1:0] beats_of(input logic [SIZE_W-1:0] size);
    if (size <= SIZE_W'(BEAT_BYTES_LOG2)) begin
      return BEATS_W'(1);
    end
    return BEATS_W'(1) << (size - SIZE_W'(BEAT_BYTES_LOG2));
  endfunction

endpackage

// File: rtl/tl_tracker_out_stage.sv
// One-entry pipe register holding the outgoing TL response header.
// Ports: clock/reset (async active-low), in_valid/in_ready/in_data upstream,
// out_valid/out_ready/out_data downstream. Accepts a new entry in the same
// cycle the held one drains; holds data stable while stalled.
module tl_tracker_out_stage
  import tl_tracker_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  out_hdr_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output out_hdr_t out_data
);

  assign in_ready = ~out_valid | out_ready;

  // Load on accepted input, otherwise empty once the consumer takes the entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tl_resp_state_tracker.sv
// Response-side TL state tracker: stores per-ID request state at issue and,
// on each downstream response beat, emits the TileLink response header.
// Ports: clock, reset (async active-low); io_alloc_* request-issue handshake
// with stored state; io_rsp_* downstream beat handshake; io_out_* response
// header handshake; io_busy slot-valid vector; io_err_orphan pulse for beats
// to empty slots; io_err_last_mismatch pulse when TL_TRACKER_LAST_CHECK_EN is
// defined (tied 0 otherwise).
module tl_resp_state_tracker
  import tl_tracker_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                io_alloc_valid,
  output logic                io_alloc_ready,
  input  logic [ID_W-1:0]     io_alloc_id,
  input  logic [SIZE_W-1:0]   io_alloc_bits_tl_state_size,
  input  logic [SOURCE_W-1:0] io_alloc_bits_tl_state_source,
  input  logic                io_alloc_bits_extra_id,
  input  logic                io_rsp_valid,
  output logic                io_rsp_ready,
  input  logic [ID_W-1:0]     io_rsp_id,
  input  logic                io_rsp_last,
  input  logic                io_rsp_denied,
  output logic                io_out_valid,
  input  logic                io_out_ready,
  output logic [SIZE_W-1:0]   io_out_bits_size,
  output logic [SOURCE_W-1:0] io_out_bits_source,
  output logic                io_out_bits_extra_id,
  output logic                io_out_bits_first,
  output logic                io_out_bits_last,
  output logic                io_out_bits_denied,
  output logic [NUM_IDS-1:0]  io_busy,
  output logic                io_err_orphan,
  output logic                io_err_last_mismatch
);

  logic [NUM_IDS-1:0] valid_q;
  slot_t              slot_q [NUM_IDS];
  logic [CNT_W-1:0]   cnt_q  [NUM_IDS];
  logic               err_orphan_q;

  logic               alloc_fire;
  logic               rsp_fire;
  logic               hit;
  logic               fwd;
  logic               is_last;
  slot_t              cur;
  logic [CNT_W-1:0]   cur_cnt;
  logic [BEATS_W-1:0] beats;
  out_hdr_t           hdr_in;
  out_hdr_t           hdr_out;

  // Valid is sampled before this cycle's release, so a freed slot reopens next cycle.
  assign io_alloc_ready = ~valid_q[io_alloc_id];
  assign alloc_fire     = io_alloc_valid & io_alloc_ready;
  assign rsp_fire       = io_rsp_valid & io_rsp_ready;

  assign hit     = valid_q[io_rsp_id];
  assign fwd     = rsp_fire & hit;
  assign cur     = slot_q[io_rsp_id];
  assign cur_cnt = cnt_q[io_rsp_id];
  assign beats   = beats_of(cur.size);
  assign is_last = ({1'b0, cur_cnt} == (beats - BEATS_W'(1)));

  assign hdr_in = '{size:     cur.size,
                    source:   cur.source,
                    extra_id: cur.extra_id,
                    first:    (cur_cnt == '0),
                    last:     is_last,
                    denied:   io_rsp_denied};

  // Slot table: release on final beat, fill on alloc (never the same slot in one cycle).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NUM_IDS; i++) begin
        slot_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      if (fwd) begin
        if (is_last) begin
          valid_q[io_rsp_id] <= 1'b0;
          cnt_q[io_rsp_id]   <= '0;
        end else begin
          cnt_q[io_rsp_id]   <= cur_cnt + CNT_W'(1);
        end
      end
      if (alloc_fire) begin
        valid_q[io_alloc_id] <= 1'b1;
        cnt_q[io_alloc_id]   <= '0;
        slot_q[io_alloc_id]  <= '{size:     io_alloc_bits_tl_state_size,
                                  source:   io_alloc_bits_tl_state_source,
                                  extra_id: io_alloc_bits_extra_id};
      end
    end
  end

  // Beats to empty slots are consumed and flagged, never forwarded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_orphan_q <= 1'b0;
    end else begin
      err_orphan_q <= rsp_fire & ~hit;
    end
  end

`ifdef TL_TRACKER_LAST_CHECK_EN
  logic err_last_q;

  // Flags disagreement between downstream's last marker and the beat count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_last_q <= 1'b0;
    end else begin
      err_last_q <= fwd & (io_rsp_last != is_last);
    end
  end

  assign io_err_last_mismatch = err_last_q;
`else
  logic unused_rsp_last;

  assign unused_rsp_last      = io_rsp_last;
  assign io_err_last_mismatch = 1'b0;
`endif

  tl_tracker_out_stage u_out_stage (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (fwd),
    .in_ready  (io_rsp_ready),
    .in_data   (hdr_in),
    .out_valid (io_out_valid),
    .out_ready (io_out_ready),
    .out_data  (hdr_out)
  );

  assign io_out_bits_size     = hdr_out.size;
  assign io_out_bits_source   = hdr_out.source;
  assign io_out_bits_extra_id = hdr_out.extra_id;
  assign io_out_bits_first    = hdr_out.first;
  assign io_out_bits_last     = hdr_out.last;
  assign io_out_bits_denied   = hdr_out.denied;
  assign io_busy              = valid_q;
  assign io_err_orphan        = err_orphan_q;

endmodule
